// File: rtl/axil_pkg.sv
// rtl/axil_pkg.sv - shared AXI-Lite response codes, arbiter states and round-robin pick
package axil_pkg;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] EXOKAY = 2'b01;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_ADDR = 3'd1,
    WR_RESP = 3'd2,
    RD_ADDR = 3'd3,
    RD_RESP = 3'd4
  } arb_state_e;

  // A tie goes to the master that was not served last.
  function automatic logic rr_pick(input logic [1:0] req, input logic last);
    return req[1] & (~req[0] | ~last);
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin arbiter with a registered grant index
module rr_arb2 import axil_pkg::*; (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_i,
  input  logic       last_i,
  input  logic       enable_i,
  output logic       grant_o
);

  logic grant_q, grant_d;

  always_comb begin
    grant_d = grant_q;
    if (enable_i && (|req_i)) grant_d = rr_pick(req_i, last_i);
  end

  always_ff @(posedge clk) begin
    if (rst) grant_q <= 1'b0;
    else     grant_q <= grant_d;
  end

  assign grant_o = grant_q;

endmodule

// File: rtl/axil_arb_2x1.sv
// rtl/axil_arb_2x1.sv - two-master, one-slave AXI-Lite arbiter, one transaction in flight
module axil_arb_2x1 import axil_pkg::*; #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] s0_axil_awaddr,
  input  logic [2:0]            s0_axil_awprot,
  input  logic                  s0_axil_awvalid,
  output logic                  s0_axil_awready,
  input  logic [DATA_WIDTH-1:0] s0_axil_wdata,
  input  logic [STRB_WIDTH-1:0] s0_axil_wstrb,
  input  logic                  s0_axil_wvalid,
  output logic                  s0_axil_wready,
  output logic [1:0]            s0_axil_bresp,
  output logic                  s0_axil_bvalid,
  input  logic                  s0_axil_bready,
  input  logic [ADDR_WIDTH-1:0] s0_axil_araddr,
  input  logic [2:0]            s0_axil_arprot,
  input  logic                  s0_axil_arvalid,
  output logic                  s0_axil_arready,
  output logic [DATA_WIDTH-1:0] s0_axil_rdata,
  output logic [1:0]            s0_axil_rresp,
  output logic                  s0_axil_rvalid,
  input  logic                  s0_axil_rready,
  input  logic [ADDR_WIDTH-1:0] s1_axil_awaddr,
  input  logic [2:0]            s1_axil_awprot,
  input  logic                  s1_axil_awvalid,
  output logic                  s1_axil_awready,
  input  logic [DATA_WIDTH-1:0] s1_axil_wdata,
  input  logic [STRB_WIDTH-1:0] s1_axil_wstrb,
  input  logic                  s1_axil_wvalid,
  output logic                  s1_axil_wready,
  output logic [1:0]            s1_axil_bresp,
  output logic                  s1_axil_bvalid,
  input  logic                  s1_axil_bready,
  input  logic [ADDR_WIDTH-1:0] s1_axil_araddr,
  input  logic [2:0]            s1_axil_arprot,
  input  logic                  s1_axil_arvalid,
  output logic                  s1_axil_arready,
  output logic [DATA_WIDTH-1:0] s1_axil_rdata,
  output logic [1:0]            s1_axil_rresp,
  output logic                  s1_axil_rvalid,
  input  logic                  s1_axil_rready,
  output logic [ADDR_WIDTH-1:0] m_axil_awaddr,
  output logic [2:0]            m_axil_awprot,
  output logic                  m_axil_awvalid,
  input  logic                  m_axil_awready,
  output logic [DATA_WIDTH-1:0] m_axil_wdata,
  output logic [STRB_WIDTH-1:0] m_axil_wstrb,
  output logic                  m_axil_wvalid,
  input  logic                  m_axil_wready,
  input  logic [1:0]            m_axil_bresp,
  input  logic                  m_axil_bvalid,
  output logic                  m_axil_bready,
  output logic [ADDR_WIDTH-1:0] m_axil_araddr,
  output logic [2:0]            m_axil_arprot,
  output logic                  m_axil_arvalid,
  input  logic                  m_axil_arready,
  input  logic [DATA_WIDTH-1:0] m_axil_rdata,
  input  logic [1:0]            m_axil_rresp,
  input  logic                  m_axil_rvalid,
  output logic                  m_axil_rready
);

  arb_state_e state_q, state_d;
  logic       last_q, last_d;
  logic       aw_done_q, aw_done_d;
  logic       w_done_q, w_done_d;
  logic       grant;

  logic [1:0][ADDR_WIDTH-1:0] awaddr, araddr;
  logic [1:0][2:0]            awprot, arprot;
  logic [1:0][DATA_WIDTH-1:0] wdata, rdata;
  logic [1:0][STRB_WIDTH-1:0] wstrb;
  logic [1:0][1:0]            bresp, rresp;
  logic [1:0] awvalid, wvalid, bready, arvalid, rready, req;
  logic [1:0] awready, wready, bvalid, arready, rvalid;
  logic       aw_fire, w_fire, b_fire, ar_fire, r_fire;

  assign awaddr  = {s1_axil_awaddr,  s0_axil_awaddr};
  assign awprot  = {s1_axil_awprot,  s0_axil_awprot};
  assign awvalid = {s1_axil_awvalid, s0_axil_awvalid};
  assign wdata   = {s1_axil_wdata,   s0_axil_wdata};
  assign wstrb   = {s1_axil_wstrb,   s0_axil_wstrb};
  assign wvalid  = {s1_axil_wvalid,  s0_axil_wvalid};
  assign bready  = {s1_axil_bready,  s0_axil_bready};
  assign araddr  = {s1_axil_araddr,  s0_axil_araddr};
  assign arprot  = {s1_axil_arprot,  s0_axil_arprot};
  assign arvalid = {s1_axil_arvalid, s0_axil_arvalid};
  assign rready  = {s1_axil_rready,  s0_axil_rready};
  assign req     = awvalid | arvalid;

  assign {s1_axil_awready, s0_axil_awready} = awready;
  assign {s1_axil_wready,  s0_axil_wready}  = wready;
  assign {s1_axil_bvalid,  s0_axil_bvalid}  = bvalid;
  assign {s1_axil_bresp,   s0_axil_bresp}   = bresp;
  assign {s1_axil_arready, s0_axil_arready} = arready;
  assign {s1_axil_rvalid,  s0_axil_rvalid}  = rvalid;
  assign {s1_axil_rdata,   s0_axil_rdata}   = rdata;
  assign {s1_axil_rresp,   s0_axil_rresp}   = rresp;

  assign aw_fire = m_axil_awvalid & m_axil_awready;
  assign w_fire  = m_axil_wvalid  & m_axil_wready;
  assign b_fire  = m_axil_bvalid  & m_axil_bready;
  assign ar_fire = m_axil_arvalid & m_axil_arready;
  assign r_fire  = m_axil_rvalid  & m_axil_rready;

  rr_arb2 u_rr_arb2 (
    .clk      (clk),
    .rst      (rst),
    .req_i    (req),
    .last_i   (last_q),
    .enable_i (state_q == IDLE),
    .grant_o  (grant)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      last_q    <= 1'b1;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    case (state_q)
      // The winner's own awvalid decides write-before-read.
      IDLE: if (|req) state_d = awvalid[rr_pick(req, last_q)] ? WR_ADDR : RD_ADDR;
      WR_ADDR: begin
        if ((aw_done_q | aw_fire) && (w_done_q | w_fire)) begin
          state_d   = WR_RESP;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end else begin
          aw_done_d = aw_done_q | aw_fire;
          w_done_d  = w_done_q | w_fire;
        end
      end
      WR_RESP: if (b_fire) begin
        last_d  = grant;
        state_d = IDLE;
      end
      RD_ADDR: if (ar_fire) state_d = RD_RESP;
      RD_RESP: if (r_fire) begin
        last_d  = grant;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    awready = '0; wready = '0; bvalid = '0; bresp = '0;
    arready = '0; rvalid = '0; rdata = '0; rresp = '0;
    m_axil_awaddr = '0; m_axil_awprot = '0; m_axil_awvalid = 1'b0;
    m_axil_wdata  = '0; m_axil_wstrb  = '0; m_axil_wvalid  = 1'b0;
    m_axil_bready = 1'b0;
    m_axil_araddr = '0; m_axil_arprot = '0; m_axil_arvalid = 1'b0;
    m_axil_rready = 1'b0;
    case (state_q)
      WR_ADDR: begin
        m_axil_awaddr  = awaddr[grant];
        m_axil_awprot  = awprot[grant];
        m_axil_awvalid = awvalid[grant] & ~aw_done_q;
        m_axil_wdata   = wdata[grant];
        m_axil_wstrb   = wstrb[grant];
        m_axil_wvalid  = wvalid[grant] & ~w_done_q;
        awready[grant] = m_axil_awready & ~aw_done_q;
        wready[grant]  = m_axil_wready & ~w_done_q;
      end
      WR_RESP: begin
        bvalid[grant] = m_axil_bvalid;
        bresp[grant]  = m_axil_bresp;
        m_axil_bready = bready[grant];
      end
      RD_ADDR: begin
        m_axil_araddr  = araddr[grant];
        m_axil_arprot  = arprot[grant];
        m_axil_arvalid = arvalid[grant];
        arready[grant] = m_axil_arready;
      end
      RD_RESP: begin
        rvalid[grant] = m_axil_rvalid;
        rdata[grant]  = m_axil_rdata;
        rresp[grant]  = m_axil_rresp;
        m_axil_rready = rready[grant];
      end
      default: ;
    endcase
  end

endmodule
